// File: rtl/pipe_stall_scheduler_pkg.sv
// Shared types for the pipeline stall/flush scheduler.
// Holds the FSM state enum, counter width default and control bundle.
package pipe_stall_scheduler_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC      = 2'd1,
        S_MC_HOLD = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic pc_we;
        logic pc_sel_redirect;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic exmem_flush;
        logic memwb_flush;
        logic mc_start;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN      = pipe_ctrl_t'(10'b1010101000);
    localparam pipe_ctrl_t CTRL_LOADUSE  = pipe_ctrl_t'(10'b0000111000);
    localparam pipe_ctrl_t CTRL_REDIRECT = pipe_ctrl_t'(10'b1111111000);
    localparam pipe_ctrl_t CTRL_MC_START = pipe_ctrl_t'(10'b0000000101);
    localparam pipe_ctrl_t CTRL_MC_FRZ   = pipe_ctrl_t'(10'b0000000100);
    localparam pipe_ctrl_t CTRL_MC_ABORT = pipe_ctrl_t'(10'b0000010100);
    localparam pipe_ctrl_t CTRL_MEMWAIT  = pipe_ctrl_t'(10'b0000000010);

endpackage

// File: rtl/pipe_stall_scheduler_if.sv
// Hazard inputs and pipeline-control outputs of the stall scheduler.
// master: pipeline side (drives hazards); slave: the scheduler.
interface pipe_stall_scheduler_if;

    logic load_use_haz;
    logic redirect_valid;
    logic mc_req;
    logic mc_done;
    logic dmem_req;
    logic dmem_ready;

    logic pc_we;
    logic pc_sel_redirect;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic exmem_flush;
    logic memwb_flush;
    logic mc_start;

    modport master (
        output load_use_haz, redirect_valid, mc_req,
        output mc_done, dmem_req, dmem_ready,
        input  pc_we, pc_sel_redirect, ifid_we, ifid_flush,
        input  idex_we, idex_flush, exmem_we, exmem_flush,
        input  memwb_flush, mc_start
    );

    modport slave (
        input  load_use_haz, redirect_valid, mc_req,
        input  mc_done, dmem_req, dmem_ready,
        output pc_we, pc_sel_redirect, ifid_we, ifid_flush,
        output idex_we, idex_flush, exmem_we, exmem_flush,
        output memwb_flush, mc_start
    );

endinterface

// File: rtl/pipe_stall_scheduler_sat_counter.sv
// Saturating up-counter: +1 per cycle with inc high, sticks at all-ones.
// Ports: clk, rst_n (async active-low), inc, count[W-1:0].
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_scheduler.sv
// Merges load-use, redirect, MUL/DIV and dmem-wait stalls into enables/bubbles.
// Ports: clk, rst_n, ctl (hazards in / controls out), error flag, 4 counters.
module pipe_stall_scheduler
    import pipe_stall_scheduler_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MC_TIMEOUT = 64,
    parameter int TO_W       = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipe_stall_scheduler_if.slave   ctl,
    output logic                    mc_timeout_err,
    output logic [CNT_W-1:0]        cnt_loaduse,
    output logic [CNT_W-1:0]        cnt_redirect,
    output logic [CNT_W-1:0]        cnt_memwait,
    output logic [CNT_W-1:0]        cnt_mc
);

    localparam logic [TO_W-1:0] MC_LAST = TO_W'(MC_TIMEOUT - 1);

    sched_state_t    state, next_state;
    logic [TO_W-1:0] mc_cnt;
    pipe_ctrl_t      ctrl;
    logic            memwait;
    logic            mc_enter, mc_abort;
    logic            inc_loaduse, inc_redirect, inc_mc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_RUN;
            mc_cnt         <= '0;
            mc_timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            if (mc_enter) begin
                mc_cnt <= '0;
            end else if (state == S_MC && mc_cnt != MC_LAST) begin
                mc_cnt <= mc_cnt + TO_W'(1);
            end
            if (mc_abort) begin
                mc_timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        ctrl         = CTRL_RUN;
        next_state   = state;
        mc_enter     = 1'b0;
        mc_abort     = 1'b0;
        inc_loaduse  = 1'b0;
        inc_redirect = 1'b0;
        inc_mc       = 1'b0;
        memwait      = ctl.dmem_req & ~ctl.dmem_ready;

        unique case (state)
            S_RUN: begin
                if (memwait) begin
                    next_state = S_RUN;
                end else if (ctl.mc_req) begin
                    ctrl       = CTRL_MC_START;
                    mc_enter   = 1'b1;
                    next_state = S_MC;
                end else if (ctl.redirect_valid) begin
                    // the flushed ID consumer makes any load-use moot
                    ctrl         = CTRL_REDIRECT;
                    inc_redirect = 1'b1;
                end else if (ctl.load_use_haz) begin
                    ctrl        = CTRL_LOADUSE;
                    inc_loaduse = 1'b1;
                end
            end
            S_MC: begin
                ctrl   = CTRL_MC_FRZ;
                inc_mc = 1'b1;
                if (ctl.mc_done) begin
                    if (memwait) begin
                        next_state = S_MC_HOLD;
                    end else begin
                        ctrl       = CTRL_RUN;
                        next_state = S_RUN;
                    end
                end else if (mc_cnt == MC_LAST && !memwait) begin
                    ctrl       = CTRL_MC_ABORT;
                    mc_abort   = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_MC_HOLD: begin
                if (!memwait) begin
                    next_state = S_RUN;
                end
            end
            default: begin
                next_state = S_RUN;
            end
        endcase

        if (memwait) begin
            ctrl = CTRL_MEMWAIT;
        end
        if (!rst_n) begin
            ctrl = '0;
        end
    end

    assign ctl.pc_we           = ctrl.pc_we;
    assign ctl.pc_sel_redirect = ctrl.pc_sel_redirect;
    assign ctl.ifid_we         = ctrl.ifid_we;
    assign ctl.ifid_flush      = ctrl.ifid_flush;
    assign ctl.idex_we         = ctrl.idex_we;
    assign ctl.idex_flush      = ctrl.idex_flush;
    assign ctl.exmem_we        = ctrl.exmem_we;
    assign ctl.exmem_flush     = ctrl.exmem_flush;
    assign ctl.memwb_flush     = ctrl.memwb_flush;
    assign ctl.mc_start        = ctrl.mc_start;

    sat_counter #(.W(CNT_W)) u_cnt_loaduse (
        .clk(clk), .rst_n(rst_n), .inc(inc_loaduse), .count(cnt_loaduse)
    );
    sat_counter #(.W(CNT_W)) u_cnt_redirect (
        .clk(clk), .rst_n(rst_n), .inc(inc_redirect), .count(cnt_redirect)
    );
    sat_counter #(.W(CNT_W)) u_cnt_memwait (
        .clk(clk), .rst_n(rst_n), .inc(memwait), .count(cnt_memwait)
    );
    sat_counter #(.W(CNT_W)) u_cnt_mc (
        .clk(clk), .rst_n(rst_n), .inc(inc_mc), .count(cnt_mc)
    );

endmodule

// File: tb/tb_pipe_stall_scheduler.sv
// Directed bench for pipe_stall_scheduler and its saturating counter.
// Control vector order: pc_we sel ifid_we ifid_fl idex_we idex_fl exmem_we exmem_fl memwb_fl start.
module tb_pipe_stall_scheduler;

    localparam logic [9:0] E_ZERO  = 10'b0000000000;
    localparam logic [9:0] E_RUN   = 10'b1010101000;
    localparam logic [9:0] E_LU    = 10'b0000111000;
    localparam logic [9:0] E_RD    = 10'b1111111000;
    localparam logic [9:0] E_START = 10'b0000000101;
    localparam logic [9:0] E_FRZ   = 10'b0000000100;
    localparam logic [9:0] E_ABORT = 10'b0000010100;
    localparam logic [9:0] E_MW    = 10'b0000000010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mc_timeout_err;
    logic [31:0] cnt_loaduse, cnt_redirect, cnt_memwait, cnt_mc;
    logic        sc_inc = 1'b0;
    logic [2:0]  sc_count;
    int          tests = 0;
    int          fails = 0;

    pipe_stall_scheduler_if bus ();

    pipe_stall_scheduler #(
        .CNT_W(32), .MC_TIMEOUT(64), .TO_W(7)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctl            (bus),
        .mc_timeout_err (mc_timeout_err),
        .cnt_loaduse    (cnt_loaduse),
        .cnt_redirect   (cnt_redirect),
        .cnt_memwait    (cnt_memwait),
        .cnt_mc         (cnt_mc)
    );

    sat_counter #(.W(3)) u_sc (
        .clk(clk), .rst_n(rst_n), .inc(sc_inc), .count(sc_count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl_obs();
        return {bus.pc_we, bus.pc_sel_redirect, bus.ifid_we,
                bus.ifid_flush, bus.idex_we, bus.idex_flush,
                bus.exmem_we, bus.exmem_flush, bus.memwb_flush,
                bus.mc_start};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lu, input logic rd, input logic mr,
                         input logic md, input logic dq, input logic dr);
        bus.load_use_haz   = lu;
        bus.redirect_valid = rd;
        bus.mc_req         = mr;
        bus.mc_done        = md;
        bus.dmem_req       = dq;
        bus.dmem_ready     = dr;
    endtask

    // settle, check combinational controls, advance to next negedge
    task automatic step(input string tag, input logic [9:0] exp);
        #1;
        chk(tag, {22'd0, ctrl_obs()}, {22'd0, exp});
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {22'd0, ctrl_obs()}, {22'd0, E_ZERO});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_ctrl0", {22'd0, ctrl_obs()}, {22'd0, E_ZERO});
        chk("rst_err", {31'd0, mc_timeout_err}, 32'd0);
        chk("rst_cmc", cnt_mc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("idle", E_RUN);

        // single load-use bubble
        drive(1, 0, 0, 0, 0, 0);
        step("lu", E_LU);
        chk("lu_cnt", cnt_loaduse, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        step("lu_after", E_RUN);

        // redirect wins over load-use
        do_reset();
        drive(1, 1, 0, 0, 0, 0);
        step("rd_lu", E_RD);
        chk("rd_cnt", cnt_redirect, 32'd1);
        chk("rd_lu_cnt", cnt_loaduse, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        step("rd_after", E_RUN);

        // MUL/DIV, done on the 5th freeze-cycle boundary
        do_reset();
        drive(0, 0, 1, 0, 0, 0);
        step("mc_start", E_START);
        for (int i = 0; i < 4; i++) step("mc_frz", E_FRZ);
        drive(0, 0, 1, 1, 0, 0);
        step("mc_adv", E_RUN);
        chk("mc_cnt", cnt_mc, 32'd5);
        drive(0, 0, 0, 1, 0, 0);
        step("mc_post", E_RUN);
        chk("mc_cnt_hold", cnt_mc, 32'd5);

        // mc_done coincident with a 3-cycle dmem wait
        do_reset();
        drive(0, 0, 1, 0, 0, 0);
        step("mh_start", E_START);
        step("mh_frz", E_FRZ);
        drive(0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step("mh_wait", E_MW);
        chk("mh_memwait", cnt_memwait, 32'd3);
        drive(0, 0, 1, 1, 1, 1);
        step("mh_adv", E_RUN);
        drive(0, 0, 0, 1, 0, 0);
        step("mh_post", E_RUN);
        chk("mh_cmc", cnt_mc, 32'd2);

        // redirect held off by dmem wait in S_RUN
        drive(0, 1, 0, 0, 1, 0);
        step("rdmw", E_MW);
        chk("rdmw_cnt", cnt_redirect, 32'd0);
        drive(0, 1, 0, 0, 1, 1);
        step("rdmw_go", E_RD);
        chk("rdmw_cnt2", cnt_redirect, 32'd1);

        // timeout abort
        do_reset();
        drive(0, 0, 1, 0, 0, 0);
        step("to_start", E_START);
        for (int i = 0; i < 63; i++) step("to_frz", E_FRZ);
        chk("to_err_pre", {31'd0, mc_timeout_err}, 32'd0);
        chk("to_cmc_pre", cnt_mc, 32'd63);
        step("to_abort", E_ABORT);
        chk("to_err", {31'd0, mc_timeout_err}, 32'd1);
        chk("to_cmc", cnt_mc, 32'd64);
        drive(0, 0, 0, 0, 0, 0);
        step("to_post", E_RUN);
        chk("to_sticky", {31'd0, mc_timeout_err}, 32'd1);

        // async reset in the middle of S_MC
        drive(0, 0, 1, 0, 0, 0);
        step("ar_start", E_START);
        step("ar_frz", E_FRZ);
        rst_n = 1'b0;
        #1;
        chk("ar_ctrl", {22'd0, ctrl_obs()}, {22'd0, E_ZERO});
        chk("ar_err", {31'd0, mc_timeout_err}, 32'd0);
        chk("ar_cmc", cnt_mc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step("ar_run", E_RUN);
        drive(0, 0, 1, 0, 0, 0);
        step("ar_restart", E_START);

        // saturation of a narrow counter
        do_reset();
        sc_inc = 1'b1;
        repeat (6) @(negedge clk);
        chk("sat_6", {29'd0, sc_count}, 32'd6);
        repeat (4) @(negedge clk);
        chk("sat_top", {29'd0, sc_count}, 32'd7);
        sc_inc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
